// File: rtl/keypad_scan_display.sv
// 3x3 keypad matrix scanner with new-press detection
// and a seven-segment readout of the last key.
module keypad_scan_display #(
  parameter logic [27:0] SCAN_MAX = 28'd49_999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       display_en,
  input  logic [2:0] row,
  output logic [2:0] column,
  output logic       valid_key,
  output logic [3:0] key,
  output logic       key_down,
  output logic [6:0] hex
);

  logic [27:0] div_cnt;
  logic        scan_tick;
  logic [1:0]  col_idx;
  logic [1:0]  col_next;
  logic        frame_end;
  logic        frame_seen;
  logic [3:0]  frame_key;
  logic        last_seen;
  logic        hit;
  logic [3:0]  hit_idx;
  logic [3:0]  base;
  logic        seen_now;
  logic [3:0]  key_now;

  assign scan_tick = (div_cnt == 28'd0);
  assign frame_end = scan_tick && (col_idx == 2'd2);
  assign col_next  = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Row sample for the active column; lowest row wins, then merge with frame.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 4'd0;
    base    = {2'b00, col_idx};
    if (!row[0]) begin
      hit     = 1'b1;
      hit_idx = base;
    end else if (!row[1]) begin
      hit     = 1'b1;
      hit_idx = base + 4'd3;
    end else if (!row[2]) begin
      hit     = 1'b1;
      hit_idx = base + 4'd6;
    end
    seen_now = frame_seen | hit;
    key_now  = frame_key;
    if (hit && (!frame_seen || hit_idx < frame_key))
      key_now = hit_idx;
  end

  // Down-counting scan divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_cnt <= SCAN_MAX;
    else if (clear || scan_tick)
      div_cnt <= SCAN_MAX;
    else
      div_cnt <= div_cnt - 28'd1;
  end

  // Column rotation, one step per scan tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_idx <= 2'd0;
      column  <= 3'b110;
    end else if (clear) begin
      col_idx <= 2'd0;
      column  <= 3'b110;
    end else if (scan_tick) begin
      col_idx <= col_next;
      column  <= ~(3'b001 << col_next);
    end
  end

  // Frame accumulation and new-press edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_seen <= 1'b0;
      frame_key  <= 4'd0;
      last_seen  <= 1'b0;
      key        <= 4'd0;
      valid_key  <= 1'b0;
      key_down   <= 1'b0;
    end else if (clear) begin
      frame_seen <= 1'b0;
      frame_key  <= 4'd0;
      last_seen  <= 1'b0;
      key        <= 4'd0;
      valid_key  <= 1'b0;
      key_down   <= 1'b0;
    end else begin
      key_down <= 1'b0;
      if (frame_end) begin
        if (seen_now && !last_seen) begin
          key       <= key_now;
          valid_key <= 1'b1;
          key_down  <= 1'b1;
        end
        last_seen  <= seen_now;
        frame_seen <= 1'b0;
        frame_key  <= 4'd0;
      end else if (scan_tick) begin
        frame_seen <= seen_now;
        frame_key  <= key_now;
      end
    end
  end

  // Display register, refreshed only while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hex <= 7'b1111111;
    else if (display_en)
      hex <= valid_key ? seg7(key) : 7'b1111111;
  end

endmodule

// File: tb/tb_keypad_scan_display.sv
// Directed bench for keypad_scan_display with a
// behavioural 3x3 switch matrix (SCAN_MAX = 3).
module tb_keypad_scan_display;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       display_en;
  logic [2:0] row;
  logic [2:0] column;
  logic       valid_key;
  logic [3:0] key;
  logic       key_down;
  logic [6:0] hex;

  logic [8:0] pressed;
  int vectors;
  int miscompares;
  int pulses;

  keypad_scan_display #(.SCAN_MAX(28'd3)) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .display_en(display_en),
    .row(row),
    .column(column),
    .valid_key(valid_key),
    .key(key),
    .key_down(key_down),
    .hex(hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !column[c])
          row[r] = 1'b0;
  end

  always @(posedge clk)
    if (key_down === 1'b1)
      pulses <= pulses + 1;

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      @(negedge clk);
  endtask

  task automatic wait_pulse(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (key_down === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic align_frame();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (column == 3'b011) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (column == 3'b110) begin
          ok = 1'b1;
          break;
        end
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL align_frame: column scan stalled, column=%b", column);
    end
  endtask

  task automatic test_reset();
    logic [2:0] exp_col;
    int p0;
    reset = 1'b1;
    run(2);
    vectors++;
    if (column !== 3'b110) begin
      miscompares++;
      $display("FAIL rst_column: got %b want 110", column);
    end
    vectors++;
    if (hex !== 7'b1111111) begin
      miscompares++;
      $display("FAIL rst_hex: got %b want 1111111", hex);
    end
    vectors++;
    if (valid_key !== 1'b0 || key !== 4'd0 || key_down !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_key: got v=%b k=%0d d=%b want 0 0 0",
               valid_key, key, key_down);
    end
    p0 = pulses;
    reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      exp_col = ~(3'b001 << ((k / 4) % 3));
      vectors++;
      if (column !== exp_col) begin
        miscompares++;
        $display("FAIL scan_col edge %0d: got %b want %b", k, column, exp_col);
      end
    end
    vectors++;
    if (pulses != p0 || valid_key !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_pulse: got pulses=%0d valid=%b want 0 0",
               pulses - p0, valid_key);
    end
  endtask

  task automatic test_single_press();
    bit found;
    int p0;
    align_frame();
    p0 = pulses;
    pressed = 9'b1 << 5;
    wait_pulse(found);
    vectors++;
    if (!found || key !== 4'd5 || valid_key !== 1'b1) begin
      miscompares++;
      $display("FAIL press5: got found=%b k=%0d v=%b want 1 5 1",
               found, key, valid_key);
    end
    vectors++;
    if (hex !== 7'b1111111) begin
      miscompares++;
      $display("FAIL press5_hex_lat: got %b want 1111111", hex);
    end
    @(negedge clk);
    vectors++;
    if (hex !== 7'b0010010 || key_down !== 1'b0) begin
      miscompares++;
      $display("FAIL press5_hex: got %b d=%b want 0010010 0", hex, key_down);
    end
    run(24);
    vectors++;
    if (pulses - p0 != 1) begin
      miscompares++;
      $display("FAIL press5_once: got %0d pulses want 1", pulses - p0);
    end
  endtask

  task automatic test_repress();
    bit found;
    pressed = '0;
    run(24);
    align_frame();
    pressed = 9'b1 << 0;
    wait_pulse(found);
    @(negedge clk);
    vectors++;
    if (!found || key !== 4'd0 || hex !== 7'b1000000) begin
      miscompares++;
      $display("FAIL press0: got found=%b k=%0d hex=%b want 1 0 1000000",
               found, key, hex);
    end
    pressed = '0;
    run(24);
    align_frame();
    pressed = 9'b1 << 8;
    wait_pulse(found);
    @(negedge clk);
    vectors++;
    if (!found || key !== 4'd8 || hex !== 7'b0000000) begin
      miscompares++;
      $display("FAIL press8: got found=%b k=%0d hex=%b want 1 8 0000000",
               found, key, hex);
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    int p0;
    pressed = '0;
    run(24);
    align_frame();
    p0 = pulses;
    pressed = (9'b1 << 7) | (9'b1 << 3);
    wait_pulse(found);
    vectors++;
    if (!found || key !== 4'd3) begin
      miscompares++;
      $display("FAIL multi_key: got found=%b k=%0d want 1 3", found, key);
    end
    run(30);
    vectors++;
    if (pulses - p0 != 1) begin
      miscompares++;
      $display("FAIL multi_once: got %0d pulses want 1", pulses - p0);
    end
  endtask

  task automatic test_clear();
    bit found;
    int p0;
    pressed = '0;
    run(24);
    align_frame();
    pressed = 9'b1 << 1;
    wait_pulse(found);
    vectors++;
    if (!found || key !== 4'd1) begin
      miscompares++;
      $display("FAIL press1: got found=%b k=%0d want 1 1", found, key);
    end
    run(6);
    p0 = pulses;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    vectors++;
    if (valid_key !== 1'b0 || key !== 4'd0 || column !== 3'b110 ||
        key_down !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_state: got v=%b k=%0d col=%b d=%b want 0 0 110 0",
               valid_key, key, column, key_down);
    end
    @(negedge clk);
    vectors++;
    if (hex !== 7'b1111111) begin
      miscompares++;
      $display("FAIL clr_hex: got %b want 1111111", hex);
    end
    run(2);
    vectors++;
    if (column !== 3'b110) begin
      miscompares++;
      $display("FAIL clr_div_hold: got %b want 110", column);
    end
    @(negedge clk);
    vectors++;
    if (column !== 3'b101) begin
      miscompares++;
      $display("FAIL clr_div_tick: got %b want 101", column);
    end
    wait_pulse(found);
    vectors++;
    if (!found || key !== 4'd1 || valid_key !== 1'b1 || pulses - p0 != 0) begin
      miscompares++;
      $display("FAIL clr_repulse: got found=%b k=%0d v=%b prior=%0d want 1 1 1 0",
               found, key, valid_key, pulses - p0);
    end
  endtask

  task automatic test_display_and_async_reset();
    bit found;
    pressed = '0;
    run(24);
    align_frame();
    display_en = 1'b0;
    pressed = 9'b1 << 4;
    wait_pulse(found);
    run(3);
    vectors++;
    if (!found || key !== 4'd4 || hex !== 7'b1111001) begin
      miscompares++;
      $display("FAIL disp_hold: got found=%b k=%0d hex=%b want 1 4 1111001",
               found, key, hex);
    end
    display_en = 1'b1;
    @(negedge clk);
    vectors++;
    if (hex !== 7'b0011001) begin
      miscompares++;
      $display("FAIL disp_en: got %b want 0011001", hex);
    end
    run(5);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (column !== 3'b110 || key !== 4'd0 || valid_key !== 1'b0 ||
        key_down !== 1'b0 || hex !== 7'b1111111) begin
      miscompares++;
      $display("FAIL async_rst: got col=%b k=%0d v=%b d=%b hex=%b",
               column, key, valid_key, key_down, hex);
    end
    pressed = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pulses      = 0;
    reset       = 1'b1;
    clear       = 1'b0;
    display_en  = 1'b1;
    pressed     = '0;
    test_reset();
    test_single_press();
    test_repress();
    test_simultaneous();
    test_clear();
    test_display_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scan_display.md
# keypad_scan_display

Input and display front end for the whack-a-mole game. It scans a 3×3 push-button matrix at a divided rate and detects new presses. It reports a one-cycle press pulse with the key index, which the score logic compares against the lit lamp position. It also drives a seven-segment digit showing the last key. Internally it has three parts: a down-counting clock divider, a matrix scanner, and a binary-to-seven-segment decoder.

## Interface
- SCAN_MAX, default 28'd49_999: divider terminal count; one scan tick every SCAN_MAX+1 clocks (1 ms at 50 MHz). Legal values are ≥1.
- clk  in  1  system clock (CLOCK_50); only clock.
- reset  in  1  asynchronous, active-high; clears every register.
- clear  in  1  synchronous, active-high soft clear of the key state and the scan state.
- display_en  in  1  when high, the digit register refreshes every cycle; when low, it holds its value.
- row  in  3  matrix row sense lines, active-low (low = the button in the active column is pressed).
- column  out  3  column drive, one-hot active-low.
- valid_key  out  1  high once any key has been registered since the last reset or clear.
- key  out  4  index of the last registered key, 0..8.
- key_down  out  1  one-cycle pulse on each new press.
- hex  out  7  seven-segment pattern {g,f,e,d,c,b,a}, active-low.

## Operation
- **Divider**
  - 28-bit counter. It loads SCAN_MAX on reset or clear.
  - It decrements every cycle and reloads SCAN_MAX after reaching 0.
  - scan_tick = (counter == 0).
- **Column drive**
  - Column index c ∈ {0,1,2}. column = ~(3'b001 << c).
  - On each scan_tick, c advances 0→1→2→0. Reset and clear set c to 0.
- **Sampling**
  - On each scan_tick, row is sampled for the current c, before c advances.
  - If any row bit is low, the key index is r*3 + c, where r is the lowest-numbered low row bit.
  - A frame is three ticks (c = 0, 1, 2). Within a frame, the lowest key index sampled wins.
- **Frame end** (the tick with c = 2):
  - If a key was seen this frame and none was seen in the previous frame: key ← the frame's key, valid_key ← 1, and key_down pulses.
  - Otherwise there is no pulse, and key and valid_key hold.
  - The "seen last frame" flag then takes the value of "seen this frame", and the frame accumulator clears.
  - A held key therefore produces exactly one pulse. The key must be released for one full frame before it can pulse again.
- **Decoder**, applied when display_en = 1:
  - If valid_key = 0: hex ← 7'b1111111 (blank).
  - Otherwise hex ← the code for key: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Codes 9–F are unreachable here; the decoder still implements them.
- **Priority:** reset > clear > normal operation.

## Timing
- Reset values:
  - column = 3'b110
  - key = 0
  - valid_key = 0
  - key_down = 0
  - hex = 7'b1111111
  - divider = SCAN_MAX
  - both frame flags = 0
- Clear has the same effect one clock edge later, i.e. synchronously.
- All outputs are registered; there is no combinational path from the inputs to the outputs.
- key_down is high for exactly one clk cycle. It starts on the edge of the frame-end tick. key and valid_key update on that same edge.
- hex follows key/valid_key with 1 cycle of latency while display_en = 1.
- A first tick occurs SCAN_MAX+1 cycles after reset deasserts.
- A key change detected mid-frame is reported only at frame end.
- Clear asserted in the same cycle as a frame-end tick: clear wins, and there is no pulse.
- Rows are assumed stable for at least one full frame; no further debounce is performed.

## Test plan
1. Reset, with SCAN_MAX = 3 and no buttons pressed → column = 110, hex = 1111111, valid_key = 0. Column steps 110→101→011→110 at cycles 4, 8, 12. key_down never rises.
2. Hold row[1] low only while column[2] is low, for 3 frames → exactly one key_down pulse; key = 5, valid_key = 1. With display_en = 1, hex = 0010010 one cycle later.
3. Release for one frame, then press key 0 (row[0] in column 0) → a second pulse with key = 0 and hex = 1000000. Press key 8 (row 2, column 2) → key = 8 and hex = 0000000.
4. Keys 7 and 3 held simultaneously → a single pulse with key = 3.
5. Assert clear mid-frame while a key is held → valid_key = 0, hex blank on the next cycle, column = 110, divider reloaded. If the key is still held, one new pulse occurs at the next frame end.
6. display_en = 0 during a press of key 4 → hex holds its previous value. Raising display_en gives hex = 0011001 one cycle later. Asserting reset asynchronously mid-scan returns all outputs to their reset values immediately.
